// File: rtl/register_file.sv
// 31x32 register file with per-register pending-write counters for decode stall tracking.
// Define REGFILE_BYPASS_EN to forward the retiring writeback value and pending status to reads.
package register_file_pkg;
  typedef logic [4:0] RegisterID_t;

  typedef struct packed {
    logic        RegWrite;
    RegisterID_t rd;
    logic [31:0] Value;
  } WritebackSignals_t;
endpackage

module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned PEND_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  WritebackSignals_t i_WritebackSignals,
  input  RegisterID_t       i_rs1,
  input  RegisterID_t       i_rs2,
  output logic [31:0]       o_rs1Value,
  output logic [31:0]       o_rs2Value,
  output logic              o_rs1Pending,
  output logic              o_rs2Pending,
  input  logic              i_IssueValid,
  input  logic              i_IssueRegWrite,
  input  RegisterID_t       i_IssueRd,
  output logic              o_IssueReady
);

  localparam logic [PEND_W-1:0] CntMax = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] CntOne = PEND_W'(1);

  logic [31:0]       r_regs [1:31];
  logic [PEND_W-1:0] r_cnt  [1:31];

  // Index-0 views so x0 reads as zero with no pending writes.
  logic [31:0]       w_rd_val [32];
  logic [PEND_W-1:0] w_cnt    [32];
  logic [31:1]       w_inc;
  logic [31:1]       w_dec;
  logic              w_retire;
  logic              w_issue;

  always_comb begin
    w_rd_val[0] = '0;
    w_cnt[0]    = '0;
    for (int i = 1; i < 32; i++) begin
      w_rd_val[i] = r_regs[i];
      w_cnt[i]    = r_cnt[i];
    end
  end

  assign w_retire     = i_WritebackSignals.RegWrite && (i_WritebackSignals.rd != '0);
  assign o_IssueReady = (i_IssueRd == '0) || (w_cnt[i_IssueRd] != CntMax);
  assign w_issue      = i_IssueValid && i_IssueRegWrite && o_IssueReady && (i_IssueRd != '0);

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 1; i < 32; i++) begin
      w_inc[i] = w_issue  && (i_IssueRd == 5'(i));
      w_dec[i] = w_retire && (i_WritebackSignals.rd == 5'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
        r_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_dec[i]) begin
          r_regs[i] <= i_WritebackSignals.Value;
        end
        // Simultaneous issue and retire cancel; retire at zero is floored.
        if (w_inc[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CntOne;
        end else if (!w_inc[i] && w_dec[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - CntOne;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Gated by reset so outputs stay zero while reset is held.
  logic w_byp_en;
  assign w_byp_en = w_retire && i_reset_n;
`endif

  always_comb begin
    o_rs1Value   = w_rd_val[i_rs1];
    o_rs1Pending = (w_cnt[i_rs1] != '0);
    o_rs2Value   = w_rd_val[i_rs2];
    o_rs2Pending = (w_cnt[i_rs2] != '0);
`ifdef REGFILE_BYPASS_EN
    if (w_byp_en && (i_WritebackSignals.rd == i_rs1)) begin
      o_rs1Value   = i_WritebackSignals.Value;
      o_rs1Pending = (w_cnt[i_rs1] > CntOne);
    end
    if (w_byp_en && (i_WritebackSignals.rd == i_rs2)) begin
      o_rs2Value   = i_WritebackSignals.Value;
      o_rs2Pending = (w_cnt[i_rs2] > CntOne);
    end
`endif
  end

endmodule
